// File: rtl/rf_op_sequencer.sv
// Register-to-register operation sequencer: IDLE -> READ -> EXEC -> WRITE, one command per four cycles.
// Optional feature macro RF_ZERO_GUARD_EN: suppresses write-back to register 0.
module rf_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int OP_W    = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OP_W-1:0]    cmd_op,
    input  logic [ADDR_W-1:0]  cmd_rs,
    input  logic [ADDR_W-1:0]  cmd_rt,
    input  logic [ADDR_W-1:0]  cmd_rd,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    input  logic               cmd_wb,
    output logic [ADDR_W-1:0]  rf_rr1,
    output logic [ADDR_W-1:0]  rf_rr2,
    output logic [OP_W-1:0]    alu_op,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [ADDR_W-1:0]  rf_wr,
    output logic [DATA_W-1:0]  rf_wd,
    output logic               rf_we,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  done_result,
    output logic               done_zero
);

    // Handshake: a command transfers on a posedge where cmd_valid and cmd_ready are both high.
    // cmd_ready is high only in IDLE outside reset; command inputs are ignored at all other times.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   wr_allow;

    logic [OP_W-1:0]    op_q;
    logic [ADDR_W-1:0]  rs_q;
    logic [ADDR_W-1:0]  rt_q;
    logic [ADDR_W-1:0]  rd_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               wb_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Once accepted, a command always runs the full sequence; only reset can abandon it.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ:    state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            wb_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op;
            rs_q    <= cmd_rs;
            rt_q    <= cmd_rt;
            rd_q    <= cmd_rd;
            shamt_q <= cmd_shamt;
            wb_q    <= cmd_wb;
        end
    end

    // The register file refreshes its outputs mid-READ, so alu_result is settled by the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (state == EXEC) begin
            result_q <= alu_result;
            zero_q   <= (alu_result == '0);
        end
    end

`ifdef RF_ZERO_GUARD_EN
    assign wr_allow = (rd_q != '0);
`else
    assign wr_allow = 1'b1;
`endif

    assign cmd_ready   = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign done        = (state == WRITE);
    assign rf_we       = (state == WRITE) && wb_q && wr_allow;
    assign rf_rr1      = rs_q;
    assign rf_rr2      = rt_q;
    assign alu_op      = op_q;
    assign alu_shamt   = shamt_q;
    assign rf_wr       = rd_q;
    assign rf_wd       = result_q;
    assign done_result = result_q;
    assign done_zero   = zero_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural register file (regs[i] = i) and ALU.
module tb_rf_op_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_shamt;
  logic        cmd_wb;
  logic [4:0]  rf_rr1;
  logic [4:0]  rf_rr2;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic        busy;
  logic        done;
  logic [31:0] done_result;
  logic        done_zero;

  logic [31:0] regs [32];
  logic [31:0] rd1;
  logic [31:0] rd2;

  int total;
  int bad;

`ifdef RF_ZERO_GUARD_EN
  localparam logic        R0_WE  = 1'b0;
  localparam logic [31:0] R0_VAL = 32'd0;
`else
  localparam logic        R0_WE  = 1'b1;
  localparam logic [31:0] R0_VAL = 32'd2;
`endif

  rf_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rs      (cmd_rs),
    .cmd_rt      (cmd_rt),
    .cmd_rd      (cmd_rd),
    .cmd_shamt   (cmd_shamt),
    .cmd_wb      (cmd_wb),
    .rf_rr1      (rf_rr1),
    .rf_rr2      (rf_rr2),
    .alu_op      (alu_op),
    .alu_shamt   (alu_shamt),
    .alu_result  (alu_result),
    .rf_wr       (rf_wr),
    .rf_wd       (rf_wd),
    .rf_we       (rf_we),
    .busy        (busy),
    .done        (done),
    .done_result (done_result),
    .done_zero   (done_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: outputs refresh on negedge, write on posedge
  always @(negedge clk) begin
    rd1 = regs[rf_rr1];
    rd2 = regs[rf_rr2];
  end

  always @(posedge clk) begin
    if (rf_we) regs[rf_wr] = rf_wd;
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'b0000: alu_result = rd1 & rd2;
      4'b0001: alu_result = rd1 | rd2;
      4'b0010: alu_result = rd1 + rd2;
      4'b0110: alu_result = rd1 - rd2;
      4'b1110: alu_result = rd2 << alu_shamt;
      default: alu_result = rd1 + rd2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] shamt, input logic wb);
    cmd_op    = op;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_rd    = rd;
    cmd_shamt = shamt;
    cmd_wb    = wb;
  endtask

  task automatic scramble_cmd();
    cmd_op    = 4'($urandom_range(0, 15));
    cmd_rs    = 5'($urandom_range(0, 31));
    cmd_rt    = 5'($urandom_range(0, 31));
    cmd_rd    = 5'($urandom_range(0, 31));
    cmd_shamt = 5'($urandom_range(0, 31));
    cmd_wb    = 1'($urandom_range(0, 1));
  endtask

  // driver: entered #1 after a posedge while IDLE; leaves #1 after the posedge back into IDLE
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
                         input logic wb, input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_we);
    drive_cmd(op, rs, rt, rd, shamt, wb);
    cmd_valid = 1'b1;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    scramble_cmd();
    check({tag, ".read_busy"}, 32'(busy), 32'd1);
    check({tag, ".read_rr1"}, 32'(rf_rr1), 32'(rs));
    check({tag, ".read_rr2"}, 32'(rf_rr2), 32'(rt));
    check({tag, ".read_op"}, 32'(alu_op), 32'(op));
    check({tag, ".read_shamt"}, 32'(alu_shamt), 32'(shamt));
    check({tag, ".read_we"}, 32'(rf_we), 32'd0);
    check({tag, ".read_done"}, 32'(done), 32'd0);
    step();
    check({tag, ".exec_done"}, 32'(done), 32'd0);
    check({tag, ".exec_we"}, 32'(rf_we), 32'd0);
    check({tag, ".exec_ready"}, 32'(cmd_ready), 32'd0);
    step();
    check({tag, ".wr_done"}, 32'(done), 32'd1);
    check({tag, ".wr_we"}, 32'(rf_we), 32'(exp_we));
    check({tag, ".wr_addr"}, 32'(rf_wr), 32'(rd));
    check({tag, ".wr_data"}, rf_wd, exp_res);
    check({tag, ".result"}, done_result, exp_res);
    check({tag, ".zero"}, 32'(done_zero), 32'(exp_zero));
    check({tag, ".wr_shamt"}, 32'(alu_shamt), 32'(shamt));
    step();
    check({tag, ".idle_done"}, 32'(done), 32'd0);
    check({tag, ".idle_we"}, 32'(rf_we), 32'd0);
    check({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_shamt"}, 32'(alu_shamt), 32'(shamt));
    check({tag, ".idle_rr1"}, 32'(rf_rr1), 32'(rs));
    check({tag, ".idle_result"}, done_result, exp_res);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    drive_cmd(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // reset state
    #1;
    check("rst.ready", 32'(cmd_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.we", 32'(rf_we), 32'd0);
    check("rst.rr1", 32'(rf_rr1), 32'd0);
    check("rst.rr2", 32'(rf_rr2), 32'd0);
    check("rst.wr", 32'(rf_wr), 32'd0);
    check("rst.op", 32'(alu_op), 32'd0);
    check("rst.shamt", 32'(alu_shamt), 32'd0);
    check("rst.wd", rf_wd, 32'd0);
    check("rst.result", done_result, 32'd0);
    check("rst.zero", 32'(done_zero), 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("rel.ready", 32'(cmd_ready), 32'd1);

    // 1: add r3 = r1 + r2
    run_cmd("add", 4'b0010, 5'd1, 5'd2, 5'd3, 5'd0, 1'b1, 32'd3, 1'b0, 1'b1);
    check("add.r3", regs[3], 32'd3);

    // 2: sub r5 = r2 - r7
    run_cmd("sub", 4'b0110, 5'd2, 5'd7, 5'd5, 5'd0, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1);
    check("sub.r5", regs[5], 32'hFFFF_FFFB);

    // 3: sll r6 = r3 << 2
    run_cmd("sll", 4'b1110, 5'd0, 5'd3, 5'd6, 5'd2, 1'b1, 32'd12, 1'b0, 1'b1);
    check("sll.r6", regs[6], 32'd12);

    // 4: back-to-back RAW, cmd_valid held through busy
    drive_cmd(4'b0010, 5'd1, 5'd2, 5'd4, 5'd0, 1'b1);
    cmd_valid = 1'b1;
    step();
    drive_cmd(4'b0010, 5'd4, 5'd4, 5'd6, 5'd0, 1'b1);
    check("raw.c1_rr1", 32'(rf_rr1), 32'd1);
    check("raw.c1_ready", 32'(cmd_ready), 32'd0);
    step();
    check("raw.c2_rr1", 32'(rf_rr1), 32'd1);
    check("raw.c2_ready", 32'(cmd_ready), 32'd0);
    step();
    check("raw.c3_done", 32'(done), 32'd1);
    check("raw.c3_result", done_result, 32'd3);
    check("raw.c3_rr1", 32'(rf_rr1), 32'd1);
    step();
    check("raw.c4_ready", 32'(cmd_ready), 32'd1);
    check("raw.c4_busy", 32'(busy), 32'd0);
    check("raw.r4", regs[4], 32'd3);
    step();
    cmd_valid = 1'b0;
    check("raw.c5_busy", 32'(busy), 32'd1);
    check("raw.c5_rr1", 32'(rf_rr1), 32'd4);
    check("raw.c5_rr2", 32'(rf_rr2), 32'd4);
    step();
    step();
    check("raw.c7_done", 32'(done), 32'd1);
    check("raw.c7_result", done_result, 32'd6);
    step();
    check("raw.r6", regs[6], 32'd6);

    // 5: compute only, and r0 & r5 -> zero
    run_cmd("nowb", 4'b0000, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("nowb.r5", regs[5], 32'hFFFF_FFFB);

    // 6: reset during EXEC abandons the command
    drive_cmd(4'b0010, 5'd1, 5'd2, 5'd7, 5'd0, 1'b1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    check("rstx.exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstx.we", 32'(rf_we), 32'd0);
    check("rstx.done", 32'(done), 32'd0);
    check("rstx.busy", 32'(busy), 32'd0);
    check("rstx.ready", 32'(cmd_ready), 32'd0);
    check("rstx.result", done_result, 32'd0);
    step();
    check("rstx.hold_done", 32'(done), 32'd0);
    check("rstx.hold_we", 32'(rf_we), 32'd0);
    rst = 1'b0;
    #1;
    check("rstx.rel_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstx.after_done", 32'(done), 32'd0);
      check("rstx.after_we", 32'(rf_we), 32'd0);
    end
    check("rstx.r7", regs[7], 32'd7);

    // 7: write-back to register 0
    run_cmd("rd0", 4'b0010, 5'd1, 5'd1, 5'd0, 5'd0, 1'b1, 32'd2, 1'b0, R0_WE);
    check("rd0.r0", regs[0], R0_VAL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
